// File: rtl/d5m_pattern_tx.sv
`default_nettype none
// ============================================================================
// d5m_pattern_tx : synthetic D5M sensor with fval/lval timing and Bayer patterns
// Rev 1.0
// ============================================================================
module d5m_pattern_tx #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 960,
  parameter int H_BLANK  = 64,
  parameter int FV_SETUP = 8,
  parameter int FV_HOLD  = 8,
  parameter int V_BLANK  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  output logic        fval,
  output logic        lval,
  output logic [11:0] p_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int PH_M1  = (H_BLANK > FV_SETUP) ? H_BLANK : FV_SETUP;
  localparam int PH_M2  = (FV_HOLD > V_BLANK) ? FV_HOLD : V_BLANK;
  localparam int PH_MAX = (PH_M1 > PH_M2) ? PH_M1 : PH_M2;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PH_W-1:0] C_SETUP_LAST = PH_W'(FV_SETUP - 1);
  localparam logic [PH_W-1:0] C_HB_LAST    = PH_W'(H_BLANK - 1);
  localparam logic [PH_W-1:0] C_HOLD_LAST  = PH_W'(FV_HOLD - 1);
  localparam logic [PH_W-1:0] C_VB_LAST    = PH_W'(V_BLANK - 1);
  localparam logic [11:0]     C_X_LAST     = 12'(H_ACTIVE - 1);
  localparam logic [10:0]     C_Y_LAST     = 11'(V_ACTIVE - 1);
  localparam logic [11:0]     C_BAR_LAST   = 12'(H_ACTIVE / 8 - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_LINE   = 3'd2,
    S_HBLANK = 3'd3,
    S_HOLD   = 3'd4,
    S_VBLANK = 3'd5
  } state_t;

  state_t           r_state, w_state;
  logic [11:0]      r_x, w_x;
  logic [10:0]      r_y, w_y;
  logic [PH_W-1:0]  r_phase, w_phase;
  logic [2:0]       r_bar, w_bar;
  logic [11:0]      r_bar_px, w_bar_px;
  logic [1:0]       r_sel, w_sel;
  logic             w_fval, w_lval, w_frame_done;
  logic [11:0]      w_p_data;
  logic [15:0]      w_frame_cnt;

  // Bar index is tracked by a per-bar pixel counter so no divider is needed.
  function automatic logic [11:0] pattern(input logic [1:0] sel, input logic [11:0] px,
                                          input logic [10:0] py, input logic [2:0] bar);
    logic [2:0] c;
    logic       site;
    c       = 3'd7 - bar;
    site    = 1'b0;
    pattern = 12'h000;
    case (sel)
      2'd0: pattern = px;
      2'd1: pattern = {1'b0, py};
      2'd2: begin
        if (py[0] == px[0]) site = c[1];
        else if (!py[0])    site = c[2];
        else                site = c[0];
        pattern = {12{site}};
      end
      default: pattern = (px[4] ^ py[4]) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  always_comb begin
    w_state      = r_state;
    w_x          = r_x;
    w_y          = r_y;
    w_phase      = r_phase;
    w_bar        = r_bar;
    w_bar_px     = r_bar_px;
    w_sel        = r_sel;
    w_fval       = fval;
    w_lval       = 1'b0;
    w_p_data     = 12'h000;
    w_frame_done = 1'b0;
    w_frame_cnt  = frame_cnt;
    case (r_state)
      S_IDLE: begin
        w_fval = 1'b0;
        if (en) begin
          w_fval  = 1'b1;
          w_state = S_SETUP;
          w_phase = '0;
          w_sel   = pattern_sel;
          w_x     = 12'd0;
          w_y     = 11'd0;
        end
      end
      S_SETUP: begin
        if (r_phase == C_SETUP_LAST) begin
          w_state  = S_LINE;
          w_lval   = 1'b1;
          w_x      = 12'd0;
          w_bar    = 3'd0;
          w_bar_px = 12'd0;
          w_p_data = pattern(r_sel, 12'd0, r_y, 3'd0);
        end else begin
          w_phase = r_phase + 1'b1;
        end
      end
      S_LINE: begin
        if (r_x == C_X_LAST) begin
          w_phase = '0;
          w_state = (r_y == C_Y_LAST) ? S_HOLD : S_HBLANK;
        end else begin
          w_x    = r_x + 12'd1;
          w_lval = 1'b1;
          if (r_bar_px == C_BAR_LAST) begin
            w_bar_px = 12'd0;
            w_bar    = r_bar + 3'd1;
          end else begin
            w_bar_px = r_bar_px + 12'd1;
          end
          w_p_data = pattern(r_sel, w_x, r_y, w_bar);
        end
      end
      S_HBLANK: begin
        if (r_phase == C_HB_LAST) begin
          w_state  = S_LINE;
          w_y      = r_y + 11'd1;
          w_x      = 12'd0;
          w_bar    = 3'd0;
          w_bar_px = 12'd0;
          w_lval   = 1'b1;
          w_p_data = pattern(r_sel, 12'd0, w_y, 3'd0);
        end else begin
          w_phase = r_phase + 1'b1;
        end
      end
      S_HOLD: begin
        if (r_phase == C_HOLD_LAST) begin
          w_fval       = 1'b0;
          w_frame_done = 1'b1;
          w_frame_cnt  = frame_cnt + 16'd1;
          w_state      = S_VBLANK;
          w_phase      = '0;
        end else begin
          w_phase = r_phase + 1'b1;
        end
      end
      S_VBLANK: begin
        if (r_phase == C_VB_LAST) begin
          w_phase = '0;
          w_x     = 12'd0;
          w_y     = 11'd0;
          if (en) begin
            w_fval  = 1'b1;
            w_state = S_SETUP;
            w_sel   = pattern_sel;
          end else begin
            w_state = S_IDLE;
          end
        end else begin
          w_phase = r_phase + 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_x        <= 12'd0;
      r_y        <= 11'd0;
      r_phase    <= '0;
      r_bar      <= 3'd0;
      r_bar_px   <= 12'd0;
      r_sel      <= 2'd0;
      fval       <= 1'b0;
      lval       <= 1'b0;
      p_data     <= 12'h000;
      frame_done <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      r_state    <= w_state;
      r_x        <= w_x;
      r_y        <= w_y;
      r_phase    <= w_phase;
      r_bar      <= w_bar;
      r_bar_px   <= w_bar_px;
      r_sel      <= w_sel;
      fval       <= w_fval;
      lval       <= w_lval;
      p_data     <= w_p_data;
      frame_done <= w_frame_done;
      frame_cnt  <= w_frame_cnt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_d5m_pattern_tx.sv
`default_nettype none
// ============================================================================
// tb_d5m_pattern_tx : directed bench for d5m_pattern_tx with small frame params
// Rev 1.0
// ============================================================================
module tb_d5m_pattern_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  pattern_sel;
  logic        fval;
  logic        lval;
  logic [11:0] p_data;
  logic        frame_done;
  logic [15:0] frame_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  d5m_pattern_tx #(
    .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(3), .FV_SETUP(2), .FV_HOLD(2), .V_BLANK(5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pattern_sel(pattern_sel),
    .fval       (fval),
    .lval       (lval),
    .p_data     (p_data),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  // Observed word: {frame_cnt, frame_done, fval, lval, p_data}
  function automatic logic [30:0] obs_vec();
    return {frame_cnt, frame_done, fval, lval, p_data};
  endfunction

  task automatic chk(input string tag, input int k, input logic [30:0] obs, input logic [30:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [11:0] pix(input int sel, input int x, input int l);
    int c;
    logic on;
    c = 7 - x;
    case (sel)
      0: return 12'(x);
      1: return 12'(l);
      2: begin
        if (l % 2 == 0) on = (x % 2 == 0) ? ((c >> 1) & 1) == 1 : ((c >> 2) & 1) == 1;
        else            on = (x % 2 == 0) ? (c & 1) == 1 : ((c >> 1) & 1) == 1;
        return on ? 12'hFFF : 12'h000;
      end
      default: return ((((x >> 4) ^ (l >> 4)) & 1) == 1) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  // Frame of 50 cycles: setup 2, four 8-pixel lines with 3-cycle gaps, hold 2, vblank 5.
  function automatic logic [30:0] exp_vec(input int k, input int sel, input int base);
    logic        fv, lv, fd;
    logic [11:0] pd;
    logic [15:0] cnt;
    int          off, l, x;
    fv  = (k < 45);
    fd  = (k == 45);
    cnt = (k >= 45) ? 16'(base + 1) : 16'(base);
    lv  = 1'b0;
    pd  = 12'h000;
    if (k >= 2 && k < 43) begin
      off = k - 2;
      l   = off / 11;
      x   = off % 11;
      if (x < 8) begin
        lv = 1'b1;
        pd = pix(sel, x, l);
      end
    end
    return {cnt, fd, fv, lv, pd};
  endfunction

  task automatic run_frame(input string tag, input int sel, input int base, input int nk,
                           input int chg_k, input logic [1:0] new_sel, input int stop_k);
    for (int k = 0; k < nk; k++) begin
      @(negedge clk);
      chk(tag, k, obs_vec(), exp_vec(k, sel, base));
      if (k == chg_k)  pattern_sel = new_sel;
      if (k == stop_k) en = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    pattern_sel = 2'd0;
    repeat (3) @(negedge clk);
    chk("reset", 0, obs_vec(), 31'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_en0", 0, obs_vec(), 31'd0);
    en = 1'b1;

    run_frame("hramp", 0, 0, 50, 20, 2'd1, -1);
    run_frame("vramp", 1, 1, 50, 20, 2'd2, -1);
    run_frame("bars", 2, 2, 50, 20, 2'd3, -1);
    run_frame("checker_stop", 3, 3, 50, 20, 2'd0, 26);

    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("stopped_idle", k, obs_vec(), {16'd4, 15'd0});
    end
    en = 1'b1;

    run_frame("pre_reset", 0, 4, 17, -1, 2'd0, -1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset", 0, obs_vec(), 31'd0);
    rst_n = 1'b1;
    run_frame("after_reset", 0, 0, 50, -1, 2'd0, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
